// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result inputs, FIFO ready flags, CDB broadcast and perf outputs
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef CDB_ARB_TYPES_DEFINED
`define CDB_ARB_TYPES_DEFINED
typedef logic [3:0] nzcv_t;
typedef enum logic {FU_ALU = 1'b0, FU_LS = 1'b1} fu_t;
`endif

interface cdb_arbiter_if;
    logic                     in_alu_valid;
    logic [`ROB_IDX_SIZE-1:0] in_alu_dst_rob_index;
    logic [`GPR_SIZE-1:0]     in_alu_value;
    logic                     in_alu_set_nzcv;
    nzcv_t                    in_alu_nzcv;
    logic                     out_alu_ready;
    logic                     in_ls_valid;
    logic [`ROB_IDX_SIZE-1:0] in_ls_dst_rob_index;
    logic [`GPR_SIZE-1:0]     in_ls_value;
    logic                     out_ls_ready;
    logic                     in_rob_is_mispred;
    logic                     out_broadcast_done;
    logic [`ROB_IDX_SIZE-1:0] out_broadcast_index;
    logic [`GPR_SIZE-1:0]     out_broadcast_value;
    logic                     out_broadcast_set_nzcv;
    nzcv_t                    out_broadcast_nzcv;
    fu_t                      out_broadcast_src;
    logic [31:0]              out_perf_alu_grants;
    logic [31:0]              out_perf_ls_grants;
    logic [31:0]              out_perf_conflicts;

    modport master (
        output in_alu_valid, in_alu_dst_rob_index, in_alu_value, in_alu_set_nzcv, in_alu_nzcv,
        output in_ls_valid, in_ls_dst_rob_index, in_ls_value, in_rob_is_mispred,
        input  out_alu_ready, out_ls_ready, out_broadcast_done, out_broadcast_index,
        input  out_broadcast_value, out_broadcast_set_nzcv, out_broadcast_nzcv, out_broadcast_src,
        input  out_perf_alu_grants, out_perf_ls_grants, out_perf_conflicts
    );

    modport slave (
        input  in_alu_valid, in_alu_dst_rob_index, in_alu_value, in_alu_set_nzcv, in_alu_nzcv,
        input  in_ls_valid, in_ls_dst_rob_index, in_ls_value, in_rob_is_mispred,
        output out_alu_ready, out_ls_ready, out_broadcast_done, out_broadcast_index,
        output out_broadcast_value, out_broadcast_set_nzcv, out_broadcast_nzcv, out_broadcast_src,
        output out_perf_alu_grants, out_perf_ls_grants, out_perf_conflicts
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter over ALU/LS skid FIFOs; perf counters under CDB_ARB_PERF_EN
module cdb_arbiter #(
    parameter int FIFO_DEPTH    = 2,
    parameter int FIFO_IDX_SIZE = 1
) (
    input logic         in_clk,
    input logic         in_rst,
    cdb_arbiter_if.slave cdb
);
    typedef struct packed {
        logic [`ROB_IDX_SIZE-1:0] idx;
        logic [`GPR_SIZE-1:0]     value;
        logic                     set_nzcv;
        nzcv_t                    nzcv;
    } ent_t;

    localparam logic [FIFO_IDX_SIZE:0] FULL = (FIFO_IDX_SIZE+1)'(FIFO_DEPTH);

    ent_t                     alu_mem [FIFO_DEPTH];
    ent_t                     ls_mem  [FIFO_DEPTH];
    logic [FIFO_IDX_SIZE-1:0] alu_head, alu_tail, ls_head, ls_tail;
    logic [FIFO_IDX_SIZE:0]   alu_cnt, ls_cnt;
    fu_t                      last_grant;
    logic                     alu_rdy, ls_rdy, alu_ne, ls_ne;
    logic                     alu_push, ls_push, alu_gnt, ls_gnt;
    ent_t                     head;

    assign alu_rdy  = alu_cnt != FULL;
    assign ls_rdy   = ls_cnt != FULL;
    assign alu_ne   = alu_cnt != '0;
    assign ls_ne    = ls_cnt != '0;
    assign alu_push = cdb.in_alu_valid & alu_rdy & ~cdb.in_rob_is_mispred;
    assign ls_push  = cdb.in_ls_valid & ls_rdy & ~cdb.in_rob_is_mispred;
    assign alu_gnt  = alu_ne & (~ls_ne | last_grant == FU_LS) & ~cdb.in_rob_is_mispred;
    assign ls_gnt   = ls_ne & ~alu_gnt & ~cdb.in_rob_is_mispred;
    assign head     = alu_gnt ? alu_mem[alu_head] : ls_mem[ls_head];

    assign cdb.out_alu_ready = alu_rdy;
    assign cdb.out_ls_ready  = ls_rdy;

    // FIFO storage writes; LS entries never carry flags
    always_ff @(posedge in_clk) begin
        if (alu_push) alu_mem[alu_tail] <= '{cdb.in_alu_dst_rob_index, cdb.in_alu_value, cdb.in_alu_set_nzcv, cdb.in_alu_nzcv};
        if (ls_push) ls_mem[ls_tail] <= '{cdb.in_ls_dst_rob_index, cdb.in_ls_value, 1'b0, 4'b0};
    end

    // pointers, counts, grant history and the registered broadcast bus
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            alu_head                   <= '0;
            alu_tail                   <= '0;
            alu_cnt                    <= '0;
            ls_head                    <= '0;
            ls_tail                    <= '0;
            ls_cnt                     <= '0;
            last_grant                 <= FU_LS;
            cdb.out_broadcast_done     <= 1'b0;
            cdb.out_broadcast_index    <= '0;
            cdb.out_broadcast_value    <= '0;
            cdb.out_broadcast_set_nzcv <= 1'b0;
            cdb.out_broadcast_nzcv     <= '0;
            cdb.out_broadcast_src      <= FU_ALU;
        end else if (cdb.in_rob_is_mispred) begin
            alu_head               <= '0;
            alu_tail               <= '0;
            alu_cnt                <= '0;
            ls_head                <= '0;
            ls_tail                <= '0;
            ls_cnt                 <= '0;
            cdb.out_broadcast_done <= 1'b0;
        end else begin
            alu_tail               <= alu_tail + FIFO_IDX_SIZE'(alu_push);
            alu_head               <= alu_head + FIFO_IDX_SIZE'(alu_gnt);
            alu_cnt                <= alu_cnt + (FIFO_IDX_SIZE+1)'(alu_push) - (FIFO_IDX_SIZE+1)'(alu_gnt);
            ls_tail                <= ls_tail + FIFO_IDX_SIZE'(ls_push);
            ls_head                <= ls_head + FIFO_IDX_SIZE'(ls_gnt);
            ls_cnt                 <= ls_cnt + (FIFO_IDX_SIZE+1)'(ls_push) - (FIFO_IDX_SIZE+1)'(ls_gnt);
            cdb.out_broadcast_done <= alu_gnt | ls_gnt;
            if (alu_gnt | ls_gnt) begin
                cdb.out_broadcast_index    <= head.idx;
                cdb.out_broadcast_value    <= head.value;
                cdb.out_broadcast_set_nzcv <= head.set_nzcv;
                cdb.out_broadcast_nzcv     <= head.nzcv;
                cdb.out_broadcast_src      <= alu_gnt ? FU_ALU : FU_LS;
                last_grant                 <= alu_gnt ? FU_ALU : FU_LS;
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic [31:0] alu_grants, ls_grants, conflicts;

    // grant/conflict counters survive mispredicts, cleared only by reset
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            alu_grants <= '0;
            ls_grants  <= '0;
            conflicts  <= '0;
        end else begin
            alu_grants <= alu_grants + 32'(alu_gnt);
            ls_grants  <= ls_grants + 32'(ls_gnt);
            conflicts  <= conflicts + 32'(alu_ne & ls_ne & ~cdb.in_rob_is_mispred);
        end
    end

    assign cdb.out_perf_alu_grants = alu_grants;
    assign cdb.out_perf_ls_grants  = ls_grants;
    assign cdb.out_perf_conflicts  = conflicts;
`else
    assign cdb.out_perf_alu_grants = '0;
    assign cdb.out_perf_ls_grants  = '0;
    assign cdb.out_perf_conflicts  = '0;
`endif
endmodule
